nios_ii_i2c_sda_in: RTL and testbench

Avalon-MM slave input port that samples the I2C SDA line so Nios II firmware can read it back while bit-banging I2C, e.g. for ACK and read-data bits. It is the receive-side counterpart of the SCLK/SDA output PIOs. The block provides:
- a two-flop synchroniser on the pin;
- a programmable glitch filter;
- per-bit edge capture with an interrupt mask and a level IRQ to the Nios II.

---
 rtl/nios_ii_pio_pkg.sv | 13 +
 rtl/nios_ii_pio_in_filter.sv | 32 +++
 rtl/nios_ii_i2c_sda_in.sv | 61 ++++++
 tb/tb_nios_ii_i2c_sda_in.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/nios_ii_pio_pkg.sv
// nios_ii_pio_pkg: register map and edge-select encodings shared by the Nios II PIO family
// Contents: Avalon register addresses and EDGE_TYPE encodings.
package nios_ii_pio_pkg;
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_DIR     = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/nios_ii_pio_in_filter.sv
// nios_ii_pio_in_filter: per-bit two-flop synchroniser followed by a stability-count glitch filter
// Ports: clk, rst (async active-high), pin (raw asynchronous input), filtered (debounced level).
module nios_ii_pio_in_filter #(
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VALUE   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic filtered
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  // The count only runs while s2 disagrees with the output, so it tops out at LAST and never wraps.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1       <= RESET_VALUE;
      s2       <= RESET_VALUE;
      filtered <= RESET_VALUE;
      cnt      <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == filtered) cnt <= '0;
      else if (cnt == LAST) begin
        filtered <= s2;
        cnt      <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/nios_ii_i2c_sda_in.sv
// nios_ii_i2c_sda_in: Avalon-MM input PIO sampling I2C SDA with glitch filter, edge capture and IRQ
// Ports: clk, reset (async active-high), address/chipselect/write_n/writedata (Avalon write and
// read select), readdata (registered, read latency 1), in_port (raw pins), irq (level, active high).
module nios_ii_i2c_sda_in
  import nios_ii_pio_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               FILTER_CYCLES = 4,
  parameter int               EDGE_TYPE     = EDGE_FALL,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] filtered, filtered_d, irqmask, edgecap, rise, fall, evt, clr;
  logic [31:0] rd_mux;
  logic wr, unused;
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    nios_ii_pio_in_filter #(
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VALUE  (RESET_VALUE[i])
    ) u_filter (
      .clk     (clk),
      .rst     (reset),
      .pin     (in_port[i]),
      .filtered(filtered[i])
    );
  end
  assign unused = ^writedata;
  assign wr     = chipselect & ~write_n;
  assign rise   = filtered & ~filtered_d;
  assign fall   = ~filtered & filtered_d;
  assign evt    = EDGE_TYPE == EDGE_RISE ? rise : EDGE_TYPE == EDGE_FALL ? fall : rise | fall;
  assign clr    = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign rd_mux = address == ADDR_DATA    ? 32'(filtered) :
                  address == ADDR_IRQMASK ? 32'(irqmask)  :
                  address == ADDR_EDGECAP ? 32'(edgecap)  : 32'd0;
  // A new edge is ORed in after the clear so it survives a coincident write-1-to-clear.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      readdata   <= '0;
      irq        <= 1'b0;
      irqmask    <= '0;
      edgecap    <= '0;
      filtered_d <= RESET_VALUE;
    end else begin
      readdata   <= rd_mux;
      irq        <= |(edgecap & irqmask);
      filtered_d <= filtered;
      edgecap    <= (edgecap & ~clr) | evt;
      if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
    end
endmodule

// File: tb/tb_nios_ii_i2c_sda_in.sv
// tb_nios_ii_i2c_sda_in: scoreboard bench for the SDA input PIO (WIDTH=1, FILTER_CYCLES=4, falling edge)
module tb_nios_ii_i2c_sda_in;
  import nios_ii_pio_pkg::*;
  logic clk = 0, reset = 1, chipselect = 0, write_n = 1, irq;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [0:0] in_port = 0;
  int checks = 0, failures = 0, pend = 0;
  typedef struct {logic is_irq; logic [31:0] exp; string name;} item_t;
  item_t q[$];

  nios_ii_i2c_sda_in #(.WIDTH(1), .FILTER_CYCLES(4), .EDGE_TYPE(EDGE_FALL), .RESET_VALUE(1'b1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Expectations pushed during a cycle are compared against the outputs just after the closing edge.
  task automatic exp_rd(input logic [1:0] a, input logic [31:0] e, input string n);
    chipselect = 1;
    address = a;
    q.push_back('{1'b0, e, n});
    pend++;
  endtask

  task automatic exp_irq(input logic e, input string n);
    q.push_back('{1'b1, {31'b0, e}, n});
    pend++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1;
    write_n = 0;
    address = a;
    writedata = d;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      pend = 0;
      chipselect = 0;
      write_n = 1;
    end
  endtask

  initial begin : monitor
    int n;
    item_t it;
    forever begin
      @(posedge clk);
      n = pend;
      #1;
      for (int k = 0; k < n; k++)
        if (q.size() != 0) begin
          it = q.pop_front();
          check(it.name, it.is_irq ? {31'b0, irq} : readdata, it.exp);
        end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    step(3);
    reset = 0;
    exp_rd(ADDR_DATA, 1, "rst_data"); exp_irq(0, "rst_irq"); step;
    exp_rd(ADDR_EDGECAP, 0, "rst_edgecap"); step;
    exp_rd(ADDR_DIR, 0, "rst_dir"); step;
    exp_rd(ADDR_IRQMASK, 0, "rst_irqmask"); step;
    step;
    exp_rd(ADDR_DATA, 1, "startup_filt_c5"); step;
    exp_rd(ADDR_DATA, 0, "startup_filt_c6"); step;
    exp_rd(ADDR_EDGECAP, 1, "startup_edgecap"); exp_irq(0, "startup_irq_masked"); step;
    wr(ADDR_EDGECAP, 1); step;
    exp_rd(ADDR_EDGECAP, 0, "startup_edgecap_clr"); step;

    in_port = 1; step(10);
    wr(ADDR_IRQMASK, 1); step;
    exp_rd(ADDR_IRQMASK, 1, "irqmask_rd"); step;
    in_port = 0; step(5);
    exp_rd(ADDR_DATA, 1, "fall_filt_c5"); step;
    exp_rd(ADDR_DATA, 0, "fall_filt_c6"); exp_irq(0, "fall_irq_c7"); step;
    exp_rd(ADDR_EDGECAP, 1, "fall_edgecap_c7"); exp_irq(1, "fall_irq_c8"); step;
    step(3);

    wr(ADDR_EDGECAP, 1); step;
    exp_rd(ADDR_EDGECAP, 0, "pre_clear"); exp_irq(0, "pre_clear_irq"); step;
    in_port = 1; step(10);
    in_port = 0; step(6);
    wr(ADDR_EDGECAP, 1); step;
    exp_rd(ADDR_EDGECAP, 1, "set_beats_clear"); exp_irq(1, "set_beats_clear_irq"); step;
    wr(ADDR_EDGECAP, 1); exp_irq(1, "irq_before_clear"); step;
    exp_rd(ADDR_EDGECAP, 0, "late_clear"); exp_irq(0, "late_clear_irq"); step;

    in_port = 1; step(10);
    in_port = 0;
    for (int k = 0; k < 3; k++) begin exp_rd(ADDR_DATA, 1, "glitch_low"); step; end
    in_port = 1;
    for (int k = 0; k < 10; k++) begin exp_rd(ADDR_DATA, 1, "glitch_after"); exp_irq(0, "glitch_irq"); step; end
    exp_rd(ADDR_EDGECAP, 0, "glitch_edgecap"); step;

    wr(ADDR_IRQMASK, 0); step;
    in_port = 0; step(4);
    in_port = 1; step(12);
    exp_rd(ADDR_EDGECAP, 1, "pulse4_edgecap"); exp_irq(0, "masked_irq"); step;
    exp_rd(ADDR_DATA, 1, "pulse4_recovered"); step;
    wr(ADDR_IRQMASK, 1); exp_irq(0, "unmask_irq_same"); step;
    exp_rd(ADDR_IRQMASK, 1, "unmask_rd"); exp_irq(1, "unmask_irq_next"); step;

    in_port = 0; step(4);
    reset = 1;
    #1;
    check("async_irq", {31'b0, irq}, 0);
    check("async_readdata", readdata, 0);
    in_port = 1;
    step(2);
    reset = 0;
    exp_rd(ADDR_IRQMASK, 0, "rst2_irqmask"); exp_irq(0, "rst2_irq"); step;
    exp_rd(ADDR_EDGECAP, 0, "rst2_edgecap"); step;
    exp_rd(ADDR_DATA, 1, "rst2_data"); step;
    wr(ADDR_DIR, 32'hFFFF_FFFF); step;
    exp_rd(ADDR_DIR, 0, "dir_after_wr"); step;
    wr(ADDR_DATA, 0); step;
    exp_rd(ADDR_DATA, 1, "data_wr_ignored"); step;
    wr(ADDR_IRQMASK, 32'hFFFF_FFFF); step;
    exp_rd(ADDR_IRQMASK, 1, "irqmask_upper_zero"); step;
    step(2);
    check("queue_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
